// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: walks each instruction through fetch, decode, execute,
// memory, writeback and PC update, driving every datapath strobe and the memory handshake.
module instr_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             alu_out_we,
    output logic             lmd_we,
    output logic             reg_we,
    output logic             sp_inc,
    output logic             sp_dec,
    output logic             pc_we,
    output logic [2:0]       branch_op,
    output logic [2:0]       stack_op,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WD_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_PCUPD  = 4'd6,
        S_HALT   = 4'd7,
        S_ERROR  = 4'd8
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [5:0]       r_op;
    logic [WD_W-1:0]  r_wd;
    logic [CNT_W-1:0] r_cnt;

    logic w_mem_cls;
    logic w_mem_wr;
    logic w_mem_rd;
    logic w_wb_after_mem;
    logic w_alu_cls;
    logic w_timeout;
    logic w_in_access;

    // r_op holds the opcode captured in DECODE, so later states never depend on IR timing
    assign w_mem_cls      = (r_op == 6'h02) || (r_op == 6'h03) || ((r_op >= 6'h08) && (r_op <= 6'h0B));
    assign w_mem_wr       = (r_op == 6'h03) || (r_op == 6'h08) || (r_op == 6'h0A);
    assign w_mem_rd       = (r_op == 6'h02) || (r_op == 6'h09) || (r_op == 6'h0B);
    assign w_wb_after_mem = (r_op == 6'h02) || (r_op == 6'h09);
    assign w_alu_cls      = (r_op == 6'h00) || (r_op == 6'h01);
    assign w_in_access    = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_timeout      = (r_wd == WD_W'(MEM_TIMEOUT - 1)) && !mem_ready;

    // Next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FETCH;
                else       w_next = S_IDLE;
            end
            S_FETCH: begin
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) w_next = S_ERROR;
                else                w_next = S_FETCH;
            end
            S_DECODE: begin
                if (opcode == 6'h0C)     w_next = S_HALT;
                else if (opcode > 6'h0D) w_next = S_ERROR;
                else                     w_next = S_EXEC;
            end
            S_EXEC: begin
                if (w_mem_cls)      w_next = S_MEM;
                else if (w_alu_cls) w_next = S_WB;
                else                w_next = S_PCUPD;
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (w_wb_after_mem) w_next = S_WB;
                    else                w_next = S_PCUPD;
                end else if (w_timeout) begin
                    w_next = S_ERROR;
                end else begin
                    w_next = S_MEM;
                end
            end
            S_WB:    w_next = S_PCUPD;
            S_PCUPD: w_next = S_FETCH;
            S_HALT:  w_next = S_HALT;
            S_ERROR: w_next = S_ERROR;
            default: w_next = S_ERROR;
        endcase
    end

    // Strobe decode; ir_we and lmd_we follow mem_ready within the same cycle
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_we      = 1'b0;
        alu_out_we = 1'b0;
        lmd_we     = 1'b0;
        reg_we     = 1'b0;
        sp_inc     = 1'b0;
        sp_dec     = 1'b0;
        pc_we      = 1'b0;
        branch_op  = 3'd0;
        stack_op   = 3'd0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            S_EXEC: alu_out_we = 1'b1;
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = w_mem_wr;
                lmd_we   = mem_ready && w_mem_rd;
            end
            S_WB: reg_we = 1'b1;
            S_PCUPD: begin
                pc_we  = 1'b1;
                sp_dec = (r_op == 6'h08) || (r_op == 6'h0A);
                sp_inc = (r_op == 6'h09) || (r_op == 6'h0B);
                case (r_op)
                    6'h04:   branch_op = 3'd1;
                    6'h05:   branch_op = 3'd2;
                    6'h06:   branch_op = 3'd3;
                    6'h07:   branch_op = 3'd4;
                    default: branch_op = 3'd0;
                endcase
                case (r_op)
                    6'h08:   stack_op = 3'd1;
                    6'h09:   stack_op = 3'd2;
                    6'h0A:   stack_op = 3'd3;
                    6'h0B:   stack_op = 3'd4;
                    default: stack_op = 3'd0;
                endcase
            end
            default: mem_req = 1'b0;
        endcase
    end

    assign busy        = (r_state != S_IDLE) && (r_state != S_HALT) && (r_state != S_ERROR);
    assign halted      = (r_state == S_HALT);
    assign err         = (r_state == S_ERROR);
    assign instr_count = r_cnt;

    // State register, opcode latch, watchdog and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= 6'h00;
            r_wd    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_op <= opcode;
            // Watchdog only advances while an access stalls in place; any state change clears it
            if (w_in_access && (w_next == r_state)) r_wd <= r_wd + WD_W'(1);
            else                                    r_wd <= '0;
            if (r_state == S_PCUPD) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a per-instruction cycle-list model builds the
// expected strobe trace, which is replayed against the DUT cycle by cycle.
module tb_instr_sequencer;

    localparam int MEM_TIMEOUT = 16;

    typedef struct packed {
        logic       mem_req, mem_we, addr_sel, ir_we, alu_out_we, lmd_we, reg_we;
        logic       sp_inc, sp_dec, pc_we;
        logic [2:0] branch_op, stack_op;
        logic       busy, halted, err;
    } outv_t;

    logic        clk = 1'b0;
    logic        rst_n, start, mem_ready;
    logic [5:0]  opcode;
    logic        mem_req, mem_we, addr_sel, ir_we, alu_out_we, lmd_we, reg_we;
    logic        sp_inc, sp_dec, pc_we, busy, halted, err;
    logic [2:0]  branch_op, stack_op;
    logic [31:0] instr_count;
    outv_t       obs;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    bit          q_start[$];
    bit          q_rdy[$];
    logic [5:0]  q_op[$];
    outv_t       q_exp[$];
    logic [31:0] q_cnt[$];
    logic [31:0] m_cnt;
    logic [5:0]  m_op;

    always #5 clk = ~clk;

    assign obs = {mem_req, mem_we, addr_sel, ir_we, alu_out_we, lmd_we, reg_we,
                  sp_inc, sp_dec, pc_we, branch_op, stack_op, busy, halted, err};

    instr_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
        .alu_out_we(alu_out_we), .lmd_we(lmd_we), .reg_we(reg_we), .sp_inc(sp_inc),
        .sp_dec(sp_dec), .pc_we(pc_we), .branch_op(branch_op), .stack_op(stack_op),
        .busy(busy), .halted(halted), .err(err), .instr_count(instr_count)
    );

    function automatic bit rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input bit st, input bit rd, input outv_t e);
        q_start.push_back(st);
        q_rdy.push_back(rd);
        q_op.push_back(m_op);
        q_exp.push_back(e);
        q_cnt.push_back(m_cnt);
    endtask

    // Absorbing HALT/ERROR: a few cycles with start held high, which must be ignored
    task automatic push_dead(input bit is_halt);
        outv_t e;
        e = '0;
        if (is_halt) e.halted = 1'b1;
        else         e.err    = 1'b1;
        repeat (3) push(1'b1, rnd(), e);
    endtask

    // One memory access with 'waits' stall cycles; gives up as a timeout after MEM_TIMEOUT cycles
    task automatic model_access(input int waits, input bit data, input bit wr, input bit rd,
                                output bit ok);
        outv_t e;
        ok = 1'b1;
        for (int i = 0; i <= waits; i++) begin
            if (i == MEM_TIMEOUT) begin
                ok = 1'b0;
                break;
            end
            e          = '0;
            e.mem_req  = 1'b1;
            e.busy     = 1'b1;
            e.addr_sel = data;
            e.mem_we   = wr;
            e.ir_we    = !data && (i == waits);
            e.lmd_we   = rd && (i == waits);
            push(rnd(), (i == waits), e);
        end
        if (!ok) push_dead(1'b0);
    endtask

    task automatic model_instr(input logic [5:0] op, input int fw, input int mw);
        outv_t e;
        bit    ok;
        m_op = op;
        model_access(fw, 1'b0, 1'b0, 1'b0, ok);
        if (!ok) return;
        e = '0; e.busy = 1'b1;
        push(rnd(), rnd(), e);
        if (op == 6'h0C) begin push_dead(1'b1); return; end
        if (op > 6'h0D)  begin push_dead(1'b0); return; end
        e.alu_out_we = 1'b1;
        push(rnd(), rnd(), e);
        if (op inside {6'h02, 6'h03, [6'h08:6'h0B]}) begin
            model_access(mw, 1'b1, op inside {6'h03, 6'h08, 6'h0A},
                         op inside {6'h02, 6'h09, 6'h0B}, ok);
            if (!ok) return;
        end
        if (op inside {6'h00, 6'h01, 6'h02, 6'h09}) begin
            e = '0; e.busy = 1'b1; e.reg_we = 1'b1;
            push(rnd(), rnd(), e);
        end
        e = '0; e.busy = 1'b1; e.pc_we = 1'b1;
        if (op >= 6'h04 && op <= 6'h07) e.branch_op = 3'(op - 6'h03);
        if (op >= 6'h08 && op <= 6'h0B) e.stack_op  = 3'(op - 6'h07);
        e.sp_dec = op inside {6'h08, 6'h0A};
        e.sp_inc = op inside {6'h09, 6'h0B};
        push(rnd(), rnd(), e);
        m_cnt = m_cnt + 32'd1;
    endtask

    // Reset the DUT and seed the model with two IDLE cycles, the second carrying start
    task automatic begin_program();
        outv_t e;
        rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0; opcode = 6'h00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        q_start.delete(); q_rdy.delete(); q_op.delete(); q_exp.delete(); q_cnt.delete();
        m_cnt = 32'd0;
        m_op  = 6'h00;
        e     = '0;
        push(1'b0, rnd(), e);
        push(1'b1, rnd(), e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; mem_ready = 1'b1; opcode = 6'h00;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (obs !== outv_t'(0)) begin
            n_err++; $display("FAIL reset_outputs got %h want %h", obs, outv_t'(0));
        end
        n_cmp++;
        if (instr_count !== 32'd0) begin
            n_err++; $display("FAIL reset_count got %0d want 0", instr_count);
        end
    endtask

    task automatic test_directed();
        logic [5:0] ops[13] = '{6'h00, 6'h07, 6'h0A, 6'h0B, 6'h09, 6'h02, 6'h03,
                                6'h08, 6'h0D, 6'h01, 6'h04, 6'h05, 6'h06};
        int         fws[13] = '{0, 0, 0, 0, 0, 1, 0, 2, 0, 3, 0, 0, 1};
        int         mws[13] = '{0, 0, 2, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0};
        begin_program();
        for (int k = 0; k < 13; k++) model_instr(ops[k], fws[k], mws[k]);
        while (q_exp.size() > 0) begin
            outv_t ev; logic [31:0] ec;
            start = q_start.pop_front(); mem_ready = q_rdy.pop_front(); opcode = q_op.pop_front();
            ev = q_exp.pop_front(); ec = q_cnt.pop_front();
            @(negedge clk);
            n_cmp++;
            if (obs !== ev) begin n_err++; $display("FAIL directed cyc %0d outputs got %h want %h", cyc, obs, ev); end
            n_cmp++;
            if (instr_count !== ec) begin n_err++; $display("FAIL directed cyc %0d count got %0d want %0d", cyc, instr_count, ec); end
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_random();
        begin_program();
        for (int k = 0; k < 40; k++) begin
            logic [5:0] op;
            op = 6'($urandom_range(0, 13));
            if (op == 6'h0C) op = 6'h0D;
            model_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        model_instr(6'($urandom_range(14, 63)), 0, 0);
        while (q_exp.size() > 0) begin
            outv_t ev; logic [31:0] ec;
            start = q_start.pop_front(); mem_ready = q_rdy.pop_front(); opcode = q_op.pop_front();
            ev = q_exp.pop_front(); ec = q_cnt.pop_front();
            @(negedge clk);
            n_cmp++;
            if (obs !== ev) begin n_err++; $display("FAIL random cyc %0d outputs got %h want %h", cyc, obs, ev); end
            n_cmp++;
            if (instr_count !== ec) begin n_err++; $display("FAIL random cyc %0d count got %0d want %0d", cyc, instr_count, ec); end
            @(posedge clk); #1; cyc++;
        end
    endtask

    // Fetch stall to the limit, stall one short of it, and a data-phase timeout
    task automatic test_timeout();
        for (int v = 0; v < 3; v++) begin
            begin_program();
            if (v == 0)      model_instr(6'h00, MEM_TIMEOUT, 0);
            else if (v == 1) model_instr(6'h00, MEM_TIMEOUT - 1, 0);
            else begin
                model_instr(6'h01, 0, 0);
                model_instr(6'h02, 0, MEM_TIMEOUT + 2);
            end
            while (q_exp.size() > 0) begin
                outv_t ev; logic [31:0] ec;
                start = q_start.pop_front(); mem_ready = q_rdy.pop_front(); opcode = q_op.pop_front();
                ev = q_exp.pop_front(); ec = q_cnt.pop_front();
                @(negedge clk);
                n_cmp++;
                if (obs !== ev) begin n_err++; $display("FAIL timeout%0d cyc %0d outputs got %h want %h", v, cyc, obs, ev); end
                n_cmp++;
                if (instr_count !== ec) begin n_err++; $display("FAIL timeout%0d cyc %0d count got %0d want %0d", v, cyc, instr_count, ec); end
                @(posedge clk); #1; cyc++;
            end
        end
    endtask

    task automatic test_halt_illegal();
        for (int v = 0; v < 2; v++) begin
            begin_program();
            model_instr(6'h0D, 0, 0);
            model_instr((v == 0) ? 6'h3F : 6'h0C, 1, 0);
            while (q_exp.size() > 0) begin
                outv_t ev; logic [31:0] ec;
                start = q_start.pop_front(); mem_ready = q_rdy.pop_front(); opcode = q_op.pop_front();
                ev = q_exp.pop_front(); ec = q_cnt.pop_front();
                @(negedge clk);
                n_cmp++;
                if (obs !== ev) begin n_err++; $display("FAIL halt_illegal%0d cyc %0d outputs got %h want %h", v, cyc, obs, ev); end
                n_cmp++;
                if (instr_count !== ec) begin n_err++; $display("FAIL halt_illegal%0d cyc %0d count got %0d want %0d", v, cyc, instr_count, ec); end
                @(posedge clk); #1; cyc++;
            end
        end
    endtask

    // Reset asserted in the third MEM cycle of a stalled store must clear outputs without a clock edge
    task automatic test_reset_mid_mem();
        begin_program();
        model_instr(6'h00, 0, 0);
        model_instr(6'h03, 0, 5);
        for (int k = 0; k < 12; k++) begin
            outv_t ev; logic [31:0] ec;
            start = q_start.pop_front(); mem_ready = q_rdy.pop_front(); opcode = q_op.pop_front();
            ev = q_exp.pop_front(); ec = q_cnt.pop_front();
            @(negedge clk);
            n_cmp++;
            if (obs !== ev) begin n_err++; $display("FAIL mid_mem cyc %0d outputs got %h want %h", cyc, obs, ev); end
            n_cmp++;
            if (instr_count !== ec) begin n_err++; $display("FAIL mid_mem cyc %0d count got %0d want %0d", cyc, instr_count, ec); end
            @(posedge clk); #1; cyc++;
        end
        start = 1'b0; mem_ready = 1'b0;
        #1;
        n_cmp++;
        if ({mem_req, mem_we, addr_sel} !== 3'b111) begin
            n_err++; $display("FAIL mid_mem_pre got req/we/sel %b want 111", {mem_req, mem_we, addr_sel});
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== outv_t'(0)) begin n_err++; $display("FAIL mid_mem_rst outputs got %h want 0", obs); end
        n_cmp++;
        if (instr_count !== 32'd0) begin n_err++; $display("FAIL mid_mem_rst count got %0d want 0", instr_count); end
        @(posedge clk); #1 rst_n = 1'b1; start = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (obs !== outv_t'(0)) begin n_err++; $display("FAIL mid_mem_idle outputs got %h want 0", obs); end
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, busy} !== 2'b11) begin n_err++; $display("FAIL mid_mem_refetch got req/busy %b want 11", {mem_req, busy}); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_timeout();
        test_halt_illegal();
        test_reset_mid_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
